keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  4x4 matrix keypad input device: the CPU-side reader that pairs with the 7-seg display output driver.
//  Scans columns, samples and debounces rows, and encodes each accepted press to a hex nibble.
//  Shifts that nibble into a 32-bit digit buffer whose layout matches the display driver's data word.
//  Raises a sticky new-key flag for the CPU, which acknowledges it with cs_i.
// PARAMETERS
//  SCAN_DIV        15  column advances every 2^SCAN_DIV clk_i cycles; legal range >= 2
//  DEBOUNCE_SCANS   4  consecutive identical full-scan frames needed to accept a press or a release; >= 2
// PORTS
//  clk_i      in   1   system clock
//  reset_i    in   1   asynchronous, active-high reset
//  cs_i       in   1   read acknowledge: clears o_valid_o on the next edge
//  clr_i      in   1   synchronous clear of o_data_o
//  row_i      in   4   keypad rows, active-low, asynchronous to clk_i
//  col_o      out  4   column drive, active-low one-hot
//  o_data_o   out  32  last 8 accepted keys; newest in [3:0], oldest in [31:28]
//  o_key_o    out  4   code of the most recently accepted key
//  o_valid_o  out  1   sticky flag: a new key has been accepted since the last cs_i
// BEHAVIOUR
//  Reset values: col_o=4'b1110, o_data_o=0, o_key_o=0, o_valid_o=0, state SCAN.
//   All counters are 0; row synchroniser flops are 4'hF.
//  row_i: 2-FF synchroniser; every later use reads the synchronised value.
//  Timebase: free-running SCAN_DIV-bit counter. tick = counter all-ones.
//  On each tick:
//   - the synchronised row is sampled for the current column;
//   - col_idx increments (wraps 3->0); col_o = ~(4'b1 << col_idx).
//  Frame: one full set of 4 column samples. Frame end = tick while col_idx==3.
//   Frame result at frame end: NONE, SINGLE(code) or MULTI.
//   code = {row_idx[1:0], col_idx[1:0]} mapped through KEY_MAP.
//  FSM (evaluated only at frame end; counter cnt is 3 bits wide minimum):
//   SCAN:    SINGLE -> CONFIRM, cand=code, cnt=1. NONE or MULTI -> stay.
//   CONFIRM: SINGLE and code==cand -> cnt++.
//             On reaching cnt==DEBOUNCE_SCANS: ACCEPT, -> HELD.
//            Any other frame result -> SCAN, cnt=0.
//   HELD:    SINGLE or MULTI -> stay. NONE -> RELEASE, cnt=1.
//   RELEASE: NONE -> cnt++; on reaching cnt==DEBOUNCE_SCANS -> SCAN.
//            SINGLE or MULTI -> HELD.
//  ACCEPT, on the same edge as the accepting frame end:
//   o_data_o <= {o_data_o[27:0], cand}; o_key_o <= cand; o_valid_o <= 1.
//  A held key never repeats. A new press needs a debounced release first.
//  Latency: key stable from frame k -> accepted at the end of frame k+DEBOUNCE_SCANS-1.
//  Simultaneous events:
//   - ACCEPT with cs_i: o_valid_o stays 1 (new key wins).
//   - ACCEPT with clr_i: o_data_o = {28'b0, cand}.
//   - clr_i does not affect o_key_o or o_valid_o.
//  Reset mid-operation: any partly debounced press is discarded; all state returns to reset values.
// STRUCTURE
//  Package keypad_pkg holds:
//   - state encoding SCAN/CONFIRM/HELD/RELEASE;
//   - KEY_MAP[16] (default identity: row*4+col);
//   - frame result encoding NONE/SINGLE/MULTI.
//  Sub-module kp_row_sync: 4-bit 2-FF synchroniser, reset to 4'hF.
//  Timebase, column drive, frame collector, FSM and buffer stay in this module.
// TESTING (SCAN_DIV=2, DEBOUNCE_SCANS=4; a keypad model pulls the row low while its column is low)
//  Reset: check col_o=1110 and all outputs 0.
//   Then col_o cycles 1101, 1011, 0111, 1110, advancing every 4 clocks.
//  Press row1/col2, hold 8 frames:
//   accepted at the end of frame 4 with o_key_o=6, o_valid_o=1, o_data_o=32'h00000006.
//   No repeat while held.
//  Bounce: present 2 frames, absent 1, present 4 frames -> exactly one accept, at the end of the last frame.
//  Press/release keys 1..9 in sequence -> o_data_o=32'h23456789.
//  Acknowledge and clear:
//   - cs_i pulse -> o_valid_o=0 next edge;
//   - cs_i on the ACCEPT edge -> o_valid_o=1;
//   - clr_i on the ACCEPT edge of key A -> o_data_o=32'h0000000A.
//  Rejects:
//   - keys 0 and 5 pressed together for 6 frames -> no accept;
//   - reset_i asserted during CONFIRM -> no accept, outputs at reset values.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM state codes, per-frame
// scan result codes and the row/column -> key code map.
// Latency: n/a (constants only). Backpressure: n/a.
package keypad_pkg;

    // Debounce FSM states
    localparam logic [1:0] ST_SCAN    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Result of one full four-column scan frame
    localparam logic [1:0] FR_NONE   = 2'd0;
    localparam logic [1:0] FR_SINGLE = 2'd1;
    localparam logic [1:0] FR_MULTI  = 2'd2;

    // Raw position {row[1:0], col[1:0]} -> key code; identity by default.
    // Element i is the rightmost-first entry, so KEY_MAP[i] == i here.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8,
        4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0
    };

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchroniser for the four active-low keypad row inputs.
// Latency: 2 clk_i cycles. Backpressure: none, free-running.
// Ports: clk_i/reset_i clock and async active-high reset; i_row raw rows;
//        o_row synchronised rows (reset to all released, 4'hF).
module kp_row_sync (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] i_row,
    output logic [3:0] o_row
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_row = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad reader: scans columns, debounces whole-frame results, shifts accepted keys into a 32-bit buffer.
// Latency: key stable from frame k is accepted at the end of frame k+DEBOUNCE_SCANS-1.
// Backpressure: none; o_valid_o is sticky until cs_i, later keys still shift in and overwrite o_key_o.
// Ports: clk_i/reset_i clock and async active-high reset; cs_i clears o_valid_o; clr_i clears o_data_o;
//        row_i active-low rows; col_o active-low one-hot column drive; o_data_o last 8 keys (newest
//        in [3:0]); o_key_o last key; o_valid_o new-key flag.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 15,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cs_i,
    input  logic        clr_i,
    input  logic [3:0]  row_i,
    output logic [3:0]  col_o,
    output logic [31:0] o_data_o,
    output logic [3:0]  o_key_o,
    output logic        o_valid_o
);

    localparam int CNT_W = ($clog2(DEBOUNCE_SCANS + 1) > 3) ? $clog2(DEBOUNCE_SCANS + 1) : 3;
    localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]          w_row;
    logic [SCAN_DIV-1:0] r_div;
    logic [1:0]          r_col_idx;
    logic [1:0]          r_hits;      // rows seen pressed so far this frame, saturating at 2
    logic [3:0]          r_code;      // raw position of the single hit seen so far
    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_cand;

    logic                w_tick;
    logic                w_frame_end;
    logic [1:0]          w_cur_n;
    logic [1:0]          w_cur_row;
    logic [2:0]          w_tot;
    logic [3:0]          w_code;
    logic [1:0]          w_fr;
    logic [3:0]          w_key;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_accept;

    kp_row_sync u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_row   (row_i),
        .o_row   (w_row)
    );

    assign w_tick      = &r_div;
    assign w_frame_end = w_tick && (r_col_idx == 2'd3);
    assign col_o       = ~(4'b0001 << r_col_idx);

    // Pressed rows in the current column sample (0, 1 or 2 meaning "several")
    always_comb begin
        w_cur_n   = 2'd0;
        w_cur_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!w_row[r]) begin
                w_cur_row = 2'(r);
                if (w_cur_n != 2'd2) w_cur_n = w_cur_n + 2'd1;
            end
        end
    end

    // Fold the current sample into the frame so the frame-end tick sees all four columns
    assign w_tot  = {1'b0, r_hits} + {1'b0, w_cur_n};
    assign w_code = (w_cur_n == 2'd1) ? {w_cur_row, r_col_idx} : r_code;
    assign w_fr   = (w_tot == 3'd0) ? FR_NONE : ((w_tot == 3'd1) ? FR_SINGLE : FR_MULTI);
    assign w_key  = KEY_MAP[w_code];

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_accept  = w_frame_end && (r_state == ST_CONFIRM) && (w_fr == FR_SINGLE)
                       && (w_key == r_cand) && (w_cnt_inc == DEB_N);

    // Timebase, column index and frame collector
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
            r_hits    <= 2'd0;
            r_code    <= 4'd0;
        end else begin
            r_div <= r_div + 1'b1;
            if (w_tick) begin
                r_col_idx <= r_col_idx + 2'd1;
                if (w_frame_end) begin
                    r_hits <= 2'd0;
                    r_code <= 4'd0;
                end else begin
                    r_hits <= (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
                    r_code <= w_code;
                end
            end
        end
    end

    // Debounce FSM, advanced once per frame
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_SCAN;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
        end else if (w_frame_end) begin
            case (r_state)
                ST_SCAN: begin
                    if (w_fr == FR_SINGLE) begin
                        r_state <= ST_CONFIRM;
                        r_cand  <= w_key;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                ST_CONFIRM: begin
                    if ((w_fr == FR_SINGLE) && (w_key == r_cand)) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == DEB_N) r_state <= ST_HELD;
                    end else begin
                        r_state <= ST_SCAN;
                        r_cnt   <= '0;
                    end
                end
                ST_HELD: begin
                    if (w_fr == FR_NONE) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                default: begin  // ST_RELEASE
                    if (w_fr == FR_NONE) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == DEB_N) begin
                            r_state <= ST_SCAN;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_state <= ST_HELD;
                    end
                end
            endcase
        end
    end

    // Key buffer and CPU flag; an accept beats a same-edge cs_i or clr_i
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            o_data_o  <= 32'd0;
            o_key_o   <= 4'd0;
            o_valid_o <= 1'b0;
        end else begin
            if (w_accept) begin
                o_data_o  <= clr_i ? {28'd0, r_cand} : {o_data_o[27:0], r_cand};
                o_key_o   <= r_cand;
                o_valid_o <= 1'b1;
            end else begin
                if (clr_i) o_data_o <= 32'd0;
                if (cs_i)  o_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cs_i = 1'b0;
    logic        clr_i = 1'b0;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [31:0] o_data_o;
    logic [3:0]  o_key_o;
    logic        o_valid_o;

    logic [15:0] keys = 16'h0;   // keypad model: bit row*4+col is a held key
    int          cyc;            // clocks since reset release; frame = 16 clocks
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  sb[$];          // expected accepted keys, in order

    keypad_scanner #(.SCAN_DIV(2), .DEBOUNCE_SCANS(4)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .cs_i      (cs_i),
        .clr_i     (clr_i),
        .row_i     (row_i),
        .col_o     (col_o),
        .o_data_o  (o_data_o),
        .o_key_o   (o_key_o),
        .o_valid_o (o_valid_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // A held key pulls its row low while its column is driven low
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge just after the n-th next frame end
    task automatic wait_frames(input int n);
        repeat (n) begin
            do @(negedge clk_i); while (cyc % 16 != 0);
        end
    endtask

    task automatic wait_mod(input int m);
        do @(negedge clk_i); while (cyc % 16 != m);
    endtask

    task automatic press(input int code, input bit expect_acc);
        keys[code] = 1'b1;
        if (expect_acc) sb.push_back(4'(code));
    endtask

    task automatic cs_pulse();
        cs_i = 1'b1;
        @(negedge clk_i);
        cs_i = 1'b0;
        check("cs_ack", {31'd0, o_valid_o}, 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (o_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic pop_check(input string tag);
        logic [3:0] exp;
        check({tag, "_sb_depth"}, sb.size(), 32'd1);
        exp = sb.pop_front();
        check({tag, "_key"}, {28'd0, o_key_o}, {28'd0, exp});
        check({tag, "_data_lsn"}, {28'd0, o_data_o[3:0]}, {28'd0, exp});
    endtask

    initial begin
        logic [31:0] data_snap;

        // Reset
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        check("rst_col", {28'd0, col_o}, 32'hE);
        check("rst_data", o_data_o, 32'h0);
        check("rst_key", {28'd0, o_key_o}, 32'h0);
        check("rst_valid", {31'd0, o_valid_o}, 32'h0);

        // Column rotation, one step per 4 clocks
        repeat (4) @(negedge clk_i); check("col_1", {28'd0, col_o}, 32'hD);
        repeat (4) @(negedge clk_i); check("col_2", {28'd0, col_o}, 32'hB);
        repeat (4) @(negedge clk_i); check("col_3", {28'd0, col_o}, 32'h7);
        repeat (4) @(negedge clk_i); check("col_0", {28'd0, col_o}, 32'hE);

        // Key 6 (row1/col2) from the start of a frame; accept at the end of frame 4
        press(6, 1'b1);
        wait_frames(3);
        check("k6_not_yet", {31'd0, o_valid_o}, 32'd0);
        wait_frames(1);
        check("k6_valid", {31'd0, o_valid_o}, 32'd1);
        check("k6_data", o_data_o, 32'h00000006);
        pop_check("k6");
        cs_pulse();
        wait_frames(4);
        check("k6_no_repeat", {31'd0, o_valid_o}, 32'd0);
        check("k6_data_hold", o_data_o, 32'h00000006);
        keys = 16'h0;
        wait_frames(6);

        // Bounce: 2 present, 1 absent, 4 present
        press(3, 1'b1);
        wait_frames(2);
        keys[3] = 1'b0;
        wait_frames(1);
        keys[3] = 1'b1;
        wait_frames(3);
        check("bnc_not_yet", {31'd0, o_valid_o}, 32'd0);
        wait_frames(1);
        check("bnc_valid", {31'd0, o_valid_o}, 32'd1);
        pop_check("bnc");
        check("bnc_once", o_data_o, 32'h00000063);
        keys = 16'h0;
        wait_frames(6);

        // Keys 1..9 in sequence
        for (int k = 1; k <= 9; k++) begin
            cs_pulse();
            wait_frames(1);
            press(k, 1'b1);
            wait_valid("seq_accept");
            pop_check("seq");
            keys = 16'h0;
            wait_frames(6);
        end
        check("seq_data", o_data_o, 32'h23456789);

        // cs_i on the accepting edge: new key wins
        cs_pulse();
        wait_frames(1);
        press(12, 1'b1);
        wait_frames(3);
        wait_mod(15);
        cs_i = 1'b1;
        @(negedge clk_i);
        cs_i = 1'b0;
        check("cs_on_accept", {31'd0, o_valid_o}, 32'd1);
        pop_check("kc");
        keys = 16'h0;
        wait_frames(6);

        // clr_i on the accepting edge of key A
        cs_pulse();
        wait_frames(1);
        press(10, 1'b1);
        wait_frames(3);
        wait_mod(15);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        check("clr_on_accept", o_data_o, 32'h0000000A);
        pop_check("ka");
        keys = 16'h0;

        // Plain clr_i leaves key and flag alone
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        check("clr_data", o_data_o, 32'h0);
        check("clr_key", {28'd0, o_key_o}, 32'hA);
        check("clr_valid", {31'd0, o_valid_o}, 32'd1);
        wait_frames(6);

        // Two keys at once never accepted
        cs_pulse();
        wait_frames(1);
        data_snap = 32'h0;
        press(0, 1'b0);
        press(5, 1'b0);
        wait_frames(6);
        check("multi_valid", {31'd0, o_valid_o}, 32'd0);
        check("multi_data", o_data_o, data_snap);
        keys = 16'h0;
        wait_frames(6);

        // Buffer up one key so reset has something to clear
        press(2, 1'b1);
        wait_valid("pre_rst_accept");
        pop_check("k2");
        keys = 16'h0;
        wait_frames(6);

        // Reset during CONFIRM discards the press
        wait_frames(1);
        press(7, 1'b0);
        wait_frames(2);
        reset_i = 1'b1;
        #1;
        check("mid_rst_col", {28'd0, col_o}, 32'hE);
        check("mid_rst_data", o_data_o, 32'h0);
        check("mid_rst_key", {28'd0, o_key_o}, 32'h0);
        check("mid_rst_valid", {31'd0, o_valid_o}, 32'h0);
        keys = 16'h0;
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        wait_frames(6);
        check("post_rst_valid", {31'd0, o_valid_o}, 32'd0);
        check("post_rst_data", o_data_o, 32'h0);
        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
